// File: rtl/processor_pkg.sv
// Shared definitions for the single-cycle MIPS-subset core:
// opcode/funct encodings, ALU operation enum, word width, sign-extend helper.
package processor_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
    return {{(XLEN-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/processor_core_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port. r0 always reads zero and ignores writes. A same-cycle write/read of
// one register returns the old value (no bypass).
// Ports: clk, rst_n (async active-low, clears all registers), we/waddr/wdata
// write port, raddr_a/raddr_b -> rdata_a/rdata_b read ports.
module regfile
  import processor_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr_a,
  input  logic [4:0]      raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] regs_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? '0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/processor_core.sv
// Single-cycle MIPS-subset core (add/sub/and/or/slt, addi, lw, sw, beq, j).
// Fetch, execute and writeback happen in one clock against an external
// combinational memory.
// Ports: clk, pc_reset (async active-low), pc_enable (0 = stall),
// instr/data_out from memory, data_in/inst_addr/data_addr and the
// mem_read_ctrlsig/mem_write_ctrlsig strobes to memory.
module processor_core
  import processor_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        pc_reset,
  input  logic        pc_enable,
  input  logic [31:0] instr,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  output logic [31:0] inst_addr,
  output logic [31:0] data_addr,
  output logic        mem_read_ctrlsig,
  output logic        mem_write_ctrlsig
);

  logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
  logic [XLEN-1:0] rs_val, rt_val, simm, alu_b, alu_res, wdata;
  logic [5:0]      opcode, funct;
  logic [4:0]      rs, rt, rd, waddr;
  alu_op_e         alu_op;
  logic            we_dec, wr_rd, is_lw, is_sw, is_beq, is_j;
  logic            unused_shamt;

  assign opcode       = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign funct        = instr[5:0];
  assign unused_shamt = ^instr[10:6];
  assign simm         = sext16(instr[15:0]);

  always_comb begin
    alu_op = ALU_ADD;
    we_dec = 1'b0;
    wr_rd  = 1'b0;
    is_lw  = 1'b0;
    is_sw  = 1'b0;
    is_beq = 1'b0;
    is_j   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        wr_rd  = 1'b1;
        we_dec = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: we_dec = 1'b0;
        endcase
      end
      OP_ADDI: we_dec = 1'b1;
      OP_LW: begin
        we_dec = 1'b1;
        is_lw  = 1'b1;
      end
      OP_SW:   is_sw  = 1'b1;
      OP_BEQ:  is_beq = 1'b1;
      OP_J:    is_j   = 1'b1;
      default: ;
    endcase
  end

  assign alu_b = wr_rd ? rt_val : simm;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = rs_val + alu_b;
      ALU_SUB: alu_res = rs_val - alu_b;
      ALU_AND: alu_res = rs_val & alu_b;
      ALU_OR:  alu_res = rs_val | alu_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, $signed(rs_val) < $signed(alu_b)};
      default: alu_res = '0;
    endcase
  end

  assign waddr = wr_rd ? rd : rt;
  assign wdata = is_lw ? data_out : alu_res;

  regfile u_regfile (
    .clk     (clk),
    .rst_n   (pc_reset),
    .we      (we_dec & pc_enable),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_val),
    .rdata_b (rt_val)
  );

  assign pc_plus4 = pc_q + PC_STEP;

  always_comb begin
    pc_d = pc_plus4;
    if (is_j)
      pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (is_beq && (rs_val == rt_val))
      pc_d = pc_plus4 + {simm[29:0], 2'b00};
  end

  always_ff @(posedge clk or negedge pc_reset) begin
    if (!pc_reset)
      pc_q <= RESET_PC;
    else if (pc_enable)
      pc_q <= pc_d;
  end

  // Strobes are gated by the reset pin itself so an in-flight instruction
  // cannot touch memory while reset is held.
  assign inst_addr         = pc_q;
  assign data_addr         = rs_val + simm;
  assign data_in           = rt_val;
  assign mem_read_ctrlsig  = is_lw & pc_reset;
  assign mem_write_ctrlsig = is_sw & pc_enable & pc_reset;

endmodule

// File: tb/tb_processor_core.sv
module tb_processor_core;

  logic        clk;
  logic        pc_reset;
  logic        pc_enable;
  logic [31:0] instr;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic [31:0] inst_addr;
  logic [31:0] data_addr;
  logic        mem_read_ctrlsig;
  logic        mem_write_ctrlsig;

  int n_run;
  int n_fail;
  logic [31:0] exp_q[$];

  processor_core dut (
    .clk               (clk),
    .pc_reset          (pc_reset),
    .pc_enable         (pc_enable),
    .instr             (instr),
    .data_out          (data_out),
    .data_in           (data_in),
    .inst_addr         (inst_addr),
    .data_addr         (data_addr),
    .mem_read_ctrlsig  (mem_read_ctrlsig),
    .mem_write_ctrlsig (mem_write_ctrlsig)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  localparam logic [31:0] NOP = 32'hFC00_0000;

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_run++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: got %h but scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: got %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic expect_now(input string tag, input logic [31:0] obs, input logic [31:0] e);
    push_exp(e);
    check(tag, obs);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] dout);
    instr    = ins;
    data_out = dout;
    #1;
  endtask

  task automatic tick(input logic [31:0] exp_pc);
    push_exp(exp_pc);
    @(posedge clk);
    #1;
    check("pc", inst_addr);
    @(negedge clk);
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    pc_reset  = 1'b0;
    pc_enable = 1'b1;
    instr     = itype(6'h2B, 5'd0, 5'd1, 16'd8);
    data_out  = 32'd0;

    // reset held 5 cycles
    for (int i = 0; i < 5; i++) begin
      if (i == 4) instr = itype(6'h23, 5'd0, 5'd6, 16'd8);
      @(posedge clk);
      #1;
      expect_now("rst_pc", inst_addr, 32'h0);
      expect_now("rst_wr", {31'd0, mem_write_ctrlsig}, 32'd0);
      expect_now("rst_rd", {31'd0, mem_read_ctrlsig}, 32'd0);
    end
    @(negedge clk);
    pc_reset = 1'b1;
    drive(NOP, 32'd0);
    expect_now("rel_pc", inst_addr, 32'h0);
    tick(32'h4);
    tick(32'h8);

    // arithmetic
    drive(itype(6'h08, 5'd0, 5'd1, 16'd5), 0);        tick(32'h0C);
    drive(itype(6'h08, 5'd0, 5'd2, 16'hFFFD), 0);     tick(32'h10);
    drive(itype(6'h04, 5'd1, 5'd1, 16'd2), 0);        tick(32'h1C);
    drive(rtype(5'd1, 5'd2, 5'd3, 6'h20), 0);         tick(32'h20);
    drive(rtype(5'd1, 5'd2, 5'd4, 6'h22), 0);         tick(32'h24);
    drive(rtype(5'd2, 5'd1, 5'd5, 6'h2A), 0);         tick(32'h28);

    // stalled sw, then a stalled addi that must not write
    pc_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(itype(6'h2B, 5'd0, 5'd1, 16'd8), 0);
      else       drive(itype(6'h08, 5'd1, 5'd1, 16'd1), 0);
      expect_now("stall_wr", {31'd0, mem_write_ctrlsig}, 32'd0);
      tick(32'h28);
    end
    pc_enable = 1'b1;

    drive(itype(6'h2B, 5'd0, 5'd1, 16'd8), 0);
    expect_now("sw_addr", data_addr, 32'd8);
    expect_now("sw_data", data_in, 32'd5);
    expect_now("sw_wr", {31'd0, mem_write_ctrlsig}, 32'd1);
    expect_now("sw_rd", {31'd0, mem_read_ctrlsig}, 32'd0);
    tick(32'h2C);

    drive(itype(6'h23, 5'd0, 5'd6, 16'd8), 32'd5);
    expect_now("lw_rd", {31'd0, mem_read_ctrlsig}, 32'd1);
    expect_now("lw_wr", {31'd0, mem_write_ctrlsig}, 32'd0);
    expect_now("lw_addr", data_addr, 32'd8);
    expect_now("lw_old_rt", data_in, 32'd0);
    tick(32'h30);

    drive(itype(6'h2B, 5'd0, 5'd6, 16'd0), 0); expect_now("r6", data_in, 32'd5); tick(32'h34);
    drive(itype(6'h2B, 5'd0, 5'd3, 16'd0), 0); expect_now("r3", data_in, 32'd2); tick(32'h38);
    drive(itype(6'h2B, 5'd0, 5'd4, 16'd0), 0); expect_now("r4", data_in, 32'd8); tick(32'h3C);
    drive(itype(6'h2B, 5'd0, 5'd5, 16'd0), 0); expect_now("r5", data_in, 32'd1); tick(32'h40);
    drive(itype(6'h2B, 5'd0, 5'd2, 16'd0), 0); expect_now("r2", data_in, 32'hFFFF_FFFD); tick(32'h44);

    // branch not taken, jump
    drive(itype(6'h04, 5'd1, 5'd2, 16'd2), 0);        tick(32'h48);
    drive({6'h02, 26'h10}, 0);                        tick(32'h40);

    // r0 write discard, unknown opcode
    drive(itype(6'h08, 5'd0, 5'd0, 16'd7), 0);        tick(32'h44);
    drive(NOP, 0);
    expect_now("nop_wr", {31'd0, mem_write_ctrlsig}, 32'd0);
    expect_now("nop_rd", {31'd0, mem_read_ctrlsig}, 32'd0);
    tick(32'h48);
    drive(itype(6'h2B, 5'd0, 5'd0, 16'd0), 0); expect_now("r0", data_in, 32'd0); tick(32'h4C);

    // asynchronous reset mid-cycle
    drive(itype(6'h2B, 5'd0, 5'd1, 16'd8), 0);
    #1 pc_reset = 1'b0;
    #1;
    expect_now("async_pc", inst_addr, 32'h0);
    expect_now("async_wr", {31'd0, mem_write_ctrlsig}, 32'd0);
    @(negedge clk);
    pc_reset = 1'b1;
    drive(itype(6'h2B, 5'd0, 5'd1, 16'd8), 0);
    expect_now("r1_cleared", data_in, 32'd0);
    tick(32'h4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/processor_core.md
Name: processor_core

Overview:
- Single-cycle 32-bit MIPS-subset processor core: fetches one instruction per clock from an external combinational instruction/data memory, executes it and writes back in the same cycle.
- Sits between the system clock/reset and the unified memory block, which supplies `instr` and `data_out` combinationally and accepts `data_in` and its control strobes.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into the PC on reset.
- PC_STEP, 4, byte increment per sequential instruction.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- pc_reset  input  1  asynchronous, active-low reset.
- pc_enable  input  1  run enable; 0 = stall.
- instr  input  32  instruction word at `inst_addr`.
- data_out  input  32  memory read data at `data_addr`.
- data_in  output  32  store data to memory (rt value).
- inst_addr  output  32  current PC (byte address).
- data_addr  output  32  load/store byte address.
- mem_read_ctrlsig  output  1  high for lw.
- mem_write_ctrlsig  output  1  high for sw; memory writes on this strobe.

Behaviour:
- Reset (`pc_reset`=0, asynchronous):
  - PC = RESET_PC; all 32 registers = 0.
  - `mem_read_ctrlsig` and `mem_write_ctrlsig` are forced 0 while reset is asserted.
  - `data_addr` and `data_in` are combinational from the current state.
- Supported instructions use MIPS encodings; opcode is `instr[31:26]`.
  - R-type: opcode 0x00, funct `instr[5:0]`: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed). Result written to rd.
  - addi 0x08: rt = rs + sext(imm16).
  - lw 0x23: rt = `data_out`; `data_addr` = rs + sext(imm16).
  - sw 0x2B: `data_addr` = rs + sext(imm16); `data_in` = rt; `mem_write_ctrlsig`=1.
  - beq 0x04: if rs==rt, next PC = PC+4 + (sext(imm16)<<2).
  - j 0x02: next PC = {PC+4[31:28], instr[25:0], 2'b00}.
  - Any other opcode or funct is a NOP: PC+4, no register write, no memory strobe.
- Arithmetic:
  - 32-bit two's complement; overflow is ignored (wraps, no trap).
  - The PC wraps modulo 2^32.
- Register r0 reads 0 always; writes to r0 are discarded.
- Register file timing:
  - Two asynchronous read ports.
  - One synchronous write port, written on the rising edge.
  - A write and a read of the same register in one cycle returns the old value.
- Single-cycle timing:
  - Control, ALU, `data_addr`, `data_in` and the strobes are combinational from `instr` and register contents.
  - PC and register write commit on the rising edge.
  - Load latency is 1 instruction: a loaded value is available to the next instruction.
- `pc_enable`=0 (stall):
  - PC holds, no register write, `mem_write_ctrlsig` forced 0.
  - `mem_read_ctrlsig` still follows decode.
- Deassertion of reset mid-cycle: the first fetch is from RESET_PC on the next rising edge after release.
- Reset asserted mid-instruction aborts it: no register or memory write.

Decomposition:
- Shared package `processor_pkg` holds:
  - Opcode and funct constants.
  - ALU-operation enum: ADD, SUB, AND, OR, SLT.
  - Word-width constant 32.
- One natural sub-module: `regfile`, the 32x32 register file (2 read, 1 write, r0 hardwired).
- ALU and control decode stay inline in `processor_core`.

Test Plan:
- Reset: hold `pc_reset`=0 for 5 cycles, then release → `inst_addr`=0 during reset; 0,4,8 on successive edges; strobes 0 during reset.
- Arithmetic: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; sub r4,r1,r2; slt r5,r2,r1 → r3=2, r4=8, r5=1.
- Store/load: sw r1,8(r0) then lw r6,8(r0) → sw cycle has `data_addr`=8, `data_in`=5, `mem_write_ctrlsig`=1; lw cycle has `mem_read_ctrlsig`=1; afterwards r6=5.
- Branch/jump:
  - beq r1,r1,+2 at PC 0x10 → next PC 0x1C.
  - beq not taken → 0x14.
  - j 0x40 (instr[25:0]=0x10) → PC 0x40.
- Stall: drop `pc_enable` for 3 cycles during a sw → PC frozen, `mem_write_ctrlsig`=0, no register change; resumes correctly.
- r0 and unknown opcode: addi r0,r0,7 then opcode 0x3F → r0 stays 0, PC advances by 4, no strobes.
